// File: rtl/seven_seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_pkg
// Description : Shared constants and types for the multiplexed 4-digit
//               seven-segment display. Segment patterns are active-low in
//               abcdefgh order (bit7 = a ... bit1 = g, bit0 = dp) with the
//               decimal point left dark (bit0 = 1).
// Revision    : 1.0 - initial release
// ============================================================================
package seven_seg_pkg;

    localparam logic [7:0] SEG_OFF   = 8'hff;
    localparam logic [3:0] DIGIT_OFF = 4'hf;

    localparam logic [7:0] SEG_0 = 8'h03;
    localparam logic [7:0] SEG_1 = 8'h9f;
    localparam logic [7:0] SEG_2 = 8'h25;
    localparam logic [7:0] SEG_3 = 8'h0d;
    localparam logic [7:0] SEG_4 = 8'h99;
    localparam logic [7:0] SEG_5 = 8'h49;
    localparam logic [7:0] SEG_6 = 8'h41;
    localparam logic [7:0] SEG_7 = 8'h1f;
    localparam logic [7:0] SEG_8 = 8'h01;
    localparam logic [7:0] SEG_9 = 8'h09;
    localparam logic [7:0] SEG_A = 8'h11;
    localparam logic [7:0] SEG_B = 8'hc1;
    localparam logic [7:0] SEG_C = 8'h63;
    localparam logic [7:0] SEG_D = 8'h85;
    localparam logic [7:0] SEG_E = 8'h61;
    localparam logic [7:0] SEG_F = 8'h71;

    // Slot phase: BLANK is the anti-ghosting gap, ON drives the digit.
    typedef enum logic [0:0] {
        SLOT_BLANK = 1'b0,
        SLOT_ON    = 1'b1
    } slot_state_e;

endpackage : seven_seg_pkg
`default_nettype wire

// File: rtl/hex_to_seg.sv
`default_nettype none
// ============================================================================
// Module      : hex_to_seg
// Description : Combinational hex nibble to active-low seven-segment decoder.
//               Decimal point (bit0) is always returned dark.
// Ports       : i_hex [3:0] - nibble to display
//               o_seg [7:0] - active-low abcdefgh pattern
// Revision    : 1.0 - initial release
// ============================================================================
module hex_to_seg
    import seven_seg_pkg::*;
(
    input  logic [3:0] i_hex,
    output logic [7:0] o_seg
);

    always_comb begin
        o_seg = SEG_OFF;
        case (i_hex)
            4'h0: o_seg = SEG_0;
            4'h1: o_seg = SEG_1;
            4'h2: o_seg = SEG_2;
            4'h3: o_seg = SEG_3;
            4'h4: o_seg = SEG_4;
            4'h5: o_seg = SEG_5;
            4'h6: o_seg = SEG_6;
            4'h7: o_seg = SEG_7;
            4'h8: o_seg = SEG_8;
            4'h9: o_seg = SEG_9;
            4'ha: o_seg = SEG_A;
            4'hb: o_seg = SEG_B;
            4'hc: o_seg = SEG_C;
            4'hd: o_seg = SEG_D;
            4'he: o_seg = SEG_E;
            4'hf: o_seg = SEG_F;
            default: o_seg = SEG_OFF;
        endcase
    end

endmodule : hex_to_seg
`default_nettype wire

// File: rtl/seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_ctrl
// Description : Time-multiplexed scan controller for a shared 4-digit
//               seven-segment display. Each digit owns a slot of DIGIT_CYCLES
//               clocks whose first BLANK_CYCLES clocks are dark. Writes land in
//               a shadow buffer and are copied to the displayed registers only
//               at frame boundaries (digit 3 -> digit 0).
// Ports       : clk, reset_n (async, active-low)
//               wr_valid/wr_ready, wr_data[15:0], wr_dp[3:0], wr_blank[3:0]
//               abcdefgh[7:0] - active-low segments, bit0 = dp
//               digit[3:0]    - active-low digit enables
//               frame_start   - pulse on first cycle of each digit-0 slot
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_ctrl
    import seven_seg_pkg::*;
#(
    parameter int DIGIT_CYCLES = 50000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [15:0] wr_data,
    input  logic [3:0]  wr_dp,
    input  logic [3:0]  wr_blank,
    output logic [7:0]  abcdefgh,
    output logic [3:0]  digit,
    output logic        frame_start
);

    localparam int CW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
    localparam logic [CW-1:0] c_cnt_last  = CW'(DIGIT_CYCLES - 1);
    localparam logic [CW-1:0] c_blank_end = CW'(BLANK_CYCLES);
    localparam slot_state_e   c_state_rst = (BLANK_CYCLES == 0) ? SLOT_ON : SLOT_BLANK;

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;
    logic          r_run;          // low until the first edge after reset
    slot_state_e   r_state;
    logic          r_pending;
    logic [15:0]   r_shadow_data;
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_shadow_blank;
    logic [15:0]   r_active_data;
    logic [3:0]    r_active_dp;
    logic [3:0]    r_active_blank;
    logic [7:0]    r_seg;
    logic [3:0]    r_digit;
    logic          r_frame_start;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [CW-1:0] w_cnt_next;
    logic [1:0]    w_idx_next;
    logic          w_frame_wrap;
    logic          w_transfer;
    logic          w_accept;
    slot_state_e   w_state_next;
    logic [15:0]   w_active_data_next;
    logic [3:0]    w_active_dp_next;
    logic [3:0]    w_active_blank_next;
    logic [3:0]    w_nibble;
    logic [7:0]    w_hex_seg;
    logic [7:0]    w_seg_next;
    logic [3:0]    w_digit_next;
    logic          w_frame_start_next;

    // The first edge after reset release lands on cnt=0/idx=0 rather than
    // advancing, so that cycle is the start of a frame and carries
    // frame_start, just like every later digit-0 slot.
    always_comb begin
        w_cnt_next = r_cnt;
        w_idx_next = r_idx;
        if (!r_run) begin
            w_cnt_next = '0;
            w_idx_next = 2'd0;
        end else if (r_cnt == c_cnt_last) begin
            w_cnt_next = '0;
            w_idx_next = r_idx + 2'd1;
        end else begin
            w_cnt_next = r_cnt + CW'(1);
        end
    end

    assign w_frame_wrap = r_run && (r_cnt == c_cnt_last) && (r_idx == 2'd3);
    assign w_transfer   = w_frame_wrap && r_pending;
    // Accept and transfer are exclusive: one needs pending low, the other high.
    assign w_accept     = wr_valid && !r_pending;
    assign wr_ready     = !r_pending;

    assign w_active_data_next  = w_transfer ? r_shadow_data  : r_active_data;
    assign w_active_dp_next    = w_transfer ? r_shadow_dp    : r_active_dp;
    assign w_active_blank_next = w_transfer ? r_shadow_blank : r_active_blank;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            SLOT_BLANK: begin
                if (w_cnt_next == c_blank_end) begin
                    w_state_next = SLOT_ON;
                end
            end
            SLOT_ON: begin
                if ((BLANK_CYCLES != 0) && (w_cnt_next == '0)) begin
                    w_state_next = SLOT_BLANK;
                end
            end
            default: w_state_next = c_state_rst;
        endcase
    end

    // Everything feeding the output registers uses next-state values, so the
    // segments, digit enable and active contents switch on the same edge.
    assign w_nibble = w_active_data_next[{w_idx_next, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .i_hex (w_nibble),
        .o_seg (w_hex_seg)
    );

    always_comb begin
        w_seg_next   = SEG_OFF;
        w_digit_next = DIGIT_OFF;
        if ((w_state_next == SLOT_ON) && !w_active_blank_next[w_idx_next]) begin
            w_digit_next             = DIGIT_OFF;
            w_digit_next[w_idx_next] = 1'b0;
            w_seg_next               = w_hex_seg;
            w_seg_next[0]            = !w_active_dp_next[w_idx_next];
        end
    end

    assign w_frame_start_next = (w_cnt_next == '0) && (w_idx_next == 2'd0);

    // ------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt          <= '0;
            r_idx          <= 2'd0;
            r_run          <= 1'b0;
            r_state        <= c_state_rst;
            r_pending      <= 1'b0;
            r_shadow_data  <= 16'h0000;
            r_shadow_dp    <= 4'h0;
            r_shadow_blank <= 4'hf;
            r_active_data  <= 16'h0000;
            r_active_dp    <= 4'h0;
            r_active_blank <= 4'hf;
            r_seg          <= SEG_OFF;
            r_digit        <= DIGIT_OFF;
            r_frame_start  <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_next;
            r_idx          <= w_idx_next;
            r_run          <= 1'b1;
            r_state        <= w_state_next;
            r_active_data  <= w_active_data_next;
            r_active_dp    <= w_active_dp_next;
            r_active_blank <= w_active_blank_next;
            r_seg          <= w_seg_next;
            r_digit        <= w_digit_next;
            r_frame_start  <= w_frame_start_next;
            if (w_transfer) begin
                r_pending <= 1'b0;
            end else if (w_accept) begin
                r_pending      <= 1'b1;
                r_shadow_data  <= wr_data;
                r_shadow_dp    <= wr_dp;
                r_shadow_blank <= wr_blank;
            end
        end
    end

    assign abcdefgh    = r_seg;
    assign digit       = r_digit;
    assign frame_start = r_frame_start;

endmodule : seven_seg_scan_ctrl
`default_nettype wire

// File: tb/tb_seven_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_ctrl
// Description : Self-checking bench for seven_seg_scan_ctrl. Two instances
//               (BLANK_CYCLES=2 and BLANK_CYCLES=0) share stimulus; a frame
//               position/shadow model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_ctrl;

    localparam int D     = 8;
    localparam int FRAME = 4 * D;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        wr_valid = 1'b0;
    logic [15:0] wr_data = 16'h0;
    logic [3:0]  wr_dp = 4'h0;
    logic [3:0]  wr_blank = 4'h0;

    logic        a_ready, b_ready;
    logic [7:0]  a_seg, b_seg;
    logic [3:0]  a_digit, b_digit;
    logic        a_fs, b_fs;

    seven_seg_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(2)) u_dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_ready    (a_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .abcdefgh    (a_seg),
        .digit       (a_digit),
        .frame_start (a_fs)
    );

    seven_seg_scan_ctrl #(.DIGIT_CYCLES(D), .BLANK_CYCLES(0)) u_dut_nb (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_valid    (wr_valid),
        .wr_ready    (b_ready),
        .wr_data     (wr_data),
        .wr_dp       (wr_dp),
        .wr_blank    (wr_blank),
        .abcdefgh    (b_seg),
        .digit       (b_digit),
        .frame_start (b_fs)
    );

    always #5 clk = ~clk;

    // Reference glyphs, active-low abcdefgh, dp dark.
    logic [7:0] seg_tab [16] = '{8'h03, 8'h9f, 8'h25, 8'h0d, 8'h99, 8'h49, 8'h41, 8'h1f,
                                 8'h01, 8'h09, 8'h11, 8'hc1, 8'h63, 8'h85, 8'h61, 8'h71};

    int n_vec = 0;
    int n_err = 0;

    // Reference model: position in the scan since release plus buffers.
    bit          m_run;
    int          m_p;
    bit          m_pending;
    logic [15:0] m_sh_data, m_data;
    logic [3:0]  m_sh_dp, m_dp, m_sh_blank, m_blank;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_run     = 1'b0;
        m_p       = 0;
        m_pending = 1'b0;
        m_data    = 16'h0;
        m_dp      = 4'h0;
        m_blank   = 4'hf;
    endtask

    task automatic model_edge();
        if (reset_n) begin
            if (m_run && (m_p % FRAME == FRAME - 1) && m_pending) begin
                m_data    = m_sh_data;
                m_dp      = m_sh_dp;
                m_blank   = m_sh_blank;
                m_pending = 1'b0;
            end else if (wr_valid && !m_pending) begin
                m_sh_data  = wr_data;
                m_sh_dp    = wr_dp;
                m_sh_blank = wr_blank;
                m_pending  = 1'b1;
            end
            if (!m_run) begin
                m_run = 1'b1;
                m_p   = 0;
            end else begin
                m_p++;
            end
        end
    endtask

    task automatic expect_out(input int bc, output logic [3:0] d, output logic [7:0] s,
                              output logic fs);
        int slot, off;
        d  = 4'hf;
        s  = 8'hff;
        fs = 1'b0;
        if (m_run) begin
            slot = (m_p / D) % 4;
            off  = m_p % D;
            fs   = (m_p % FRAME) == 0;
            if (off >= bc && !m_blank[slot]) begin
                d[slot] = 1'b0;
                s       = seg_tab[m_data[slot*4 +: 4]];
                if (m_dp[slot]) s[0] = 1'b0;
            end
        end
    endtask

    task automatic compare_all();
        logic [3:0] ed;
        logic [7:0] es;
        logic       ef;
        expect_out(2, ed, es, ef);
        check_value("digit", 32'(a_digit), 32'(ed));
        check_value("seg", 32'(a_seg), 32'(es));
        check_value("frame_start", 32'(a_fs), 32'(ef));
        check_value("wr_ready", 32'(a_ready), 32'(!m_pending));
        expect_out(0, ed, es, ef);
        check_value("nb_digit", 32'(b_digit), 32'(ed));
        check_value("nb_seg", 32'(b_seg), 32'(es));
        check_value("nb_frame_start", 32'(b_fs), 32'(ef));
        check_value("nb_wr_ready", 32'(b_ready), 32'(!m_pending));
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_one(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] bl);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dp    = dp;
        wr_blank = bl;
        tick();
        wr_valid = 1'b0;
    endtask

    // Advance until the model position sits at the given frame offset.
    task automatic run_to(input int frame_off);
        int guard;
        guard = 0;
        while ((m_p % FRAME) != frame_off && guard < 2 * FRAME) begin
            tick();
            guard++;
        end
        if (guard >= 2 * FRAME) check_value("run_to_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        bit was_ready;
        int guard;
        model_reset();
        m_sh_data  = 16'h0;
        m_sh_dp    = 4'h0;
        m_sh_blank = 4'hf;

        // Reset held, then released; display stays dark for a full frame.
        @(negedge clk);
        compare_all();
        run(3);
        reset_n = 1'b1;
        run(FRAME + 2);

        // Basic write: 1F80 -> digits 0..3 show 0, 8, F, 1.
        run_to(5);
        write_one(16'h1F80, 4'b0000, 4'b0000);
        run(2 * FRAME);

        // Double buffering: A mid-frame, B held until accepted.
        run_to(12);
        write_one(16'h2345, 4'b0001, 4'b0000);
        wr_valid = 1'b1;
        wr_data  = 16'hABCD;
        wr_dp    = 4'b1000;
        wr_blank = 4'b0100;
        guard    = 0;
        do begin
            was_ready = !m_pending;
            tick();
            guard++;
        end while (!was_ready && guard < 3 * FRAME);
        if (!was_ready) check_value("accept_timeout", 32'd0, 32'd1);
        wr_valid = 1'b0;
        run(3 * FRAME);

        // Boundary collision: write presented on the wrap edge, pending clear.
        run_to(FRAME - 1);
        write_one(16'h6789, 4'b0100, 4'b0000);
        run(3 * FRAME);

        // Decimal point and per-digit blank.
        run_to(3);
        write_one(16'h0000, 4'b0010, 4'b1000);
        run(2 * FRAME);

        // Randomized traffic.
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(0, 7) == 0);
            wr_data  = 16'($urandom);
            wr_dp    = 4'($urandom);
            wr_blank = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end
        wr_valid = 1'b0;

        // Mid-slot reset with a write pending: outputs go dark at once.
        run_to(D + 4);
        write_one(16'h4321, 4'b0000, 4'b0000);
        run(2);
        reset_n = 1'b0;
        model_reset();
        #1;
        compare_all();
        wr_valid = 1'b1;
        wr_data  = 16'hFFFF;
        run(2);
        wr_valid = 1'b0;
        reset_n  = 1'b1;
        run(2 * FRAME + 3);
        write_one(16'h5A5A, 4'b1010, 4'b0000);
        run(3 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seven_seg_scan_ctrl
`default_nettype wire
